// File: rtl/gearbox_param_if.sv
// gearbox_param_if: handshake bundle for the gearbox_param width converter.
//   Producer side : in_valid, in_ready, data_in (IN_W, bit 0 oldest), flush
//   Consumer side : out_valid, out_ready, data_out (OUT_W, bit 0 oldest), out_last
//   Status        : flush_done (one-cycle pulse), level (buffered bit count)
// Modports:
//   slave  - the gearbox itself
//   master - the environment driving producer inputs and consuming the output
interface gearbox_param_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 20,
    parameter int BUF_W = 80
);
    localparam int LVL_W = $clog2(BUF_W + 1);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  data_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] data_out;
    logic             out_last;
    logic             flush_done;
    logic [LVL_W-1:0] level;

    modport slave (
        input  in_valid, data_in, flush, out_ready,
        output in_ready, out_valid, data_out, out_last, flush_done, level
    );

    modport master (
        output in_valid, data_in, flush, out_ready,
        input  in_ready, out_valid, data_out, out_last, flush_done, level
    );
endinterface

// File: rtl/gearbox_param.sv
// gearbox_param: single-clock IN_W -> OUT_W gearbox with an LSB-first bit
// accumulator, explicit flush (zero-padded final word with out_last) and a
// fill-level output.
// Ports:
//   clk - clock, all state on the rising edge
//   res - asynchronous active-high reset
//   gb  - gearbox_param_if.slave bundle (producer/consumer handshakes, status)
module gearbox_param #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 20,
    parameter int BUF_W = 80,
    localparam int LVL_W = $clog2(BUF_W + 1)
) (
    input  logic           clk,
    input  logic           res,
    gearbox_param_if.slave gb
);

    // The accumulator must hold a full output word plus one incoming word.
    generate
        if (BUF_W < IN_W + OUT_W) begin : g_buf_too_small
            $error("gearbox_param: BUF_W must be >= IN_W + OUT_W");
        end
    endgenerate

    // Fill arithmetic is one bit wider than the level output so sums never wrap.
    localparam logic [LVL_W:0] IN_W_X  = (LVL_W + 1)'(IN_W);
    localparam logic [LVL_W:0] OUT_W_X = (LVL_W + 1)'(OUT_W);
    localparam logic [LVL_W:0] BUF_W_X = (LVL_W + 1)'(BUF_W);
    localparam logic [LVL_W:0] FILL_ZERO = {(LVL_W + 1){1'b0}};

    logic [BUF_W-1:0] acc_r;          // bit 0 is the oldest buffered bit
    logic [LVL_W:0]   fill_r;         // bits above fill_r in acc_r are always 0
    logic             flush_pend_r;
    logic             flush_done_r;

    logic             in_ready_s;
    logic             out_valid_s;
    logic             padded_s;
    logic [LVL_W:0]   consumed_s;
    logic [OUT_W-1:0] pad_mask_s;
    logic [OUT_W-1:0] data_out_s;

    logic             push_s;
    logic             pop_s;
    logic [BUF_W-1:0] acc_next_s;
    logic [LVL_W:0]   fill_next_s;
    logic             pend_next_s;
    logic             done_next_s;

    // Handshake status and output word, derived from registered state only.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        padded_s    = 1'b0;
        consumed_s  = OUT_W_X;
        pad_mask_s  = {OUT_W{1'b1}};

        // Ready looks at the current fill only; a same-cycle pop does not help.
        if (res) begin
            in_ready_s = 1'b0;
        end else if (!flush_pend_r && (fill_r + IN_W_X <= BUF_W_X)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end

        if (fill_r >= OUT_W_X) begin
            out_valid_s = 1'b1;
        end else if (flush_pend_r && (fill_r != FILL_ZERO)) begin
            // Short tail during a flush: emit what is left, zero-padded.
            out_valid_s = 1'b1;
            padded_s    = 1'b1;
            consumed_s  = fill_r;
        end else begin
            out_valid_s = 1'b0;
        end

        for (int i = 0; i < OUT_W; i++) begin
            if (padded_s) begin
                pad_mask_s[i] = ((LVL_W + 1)'(i) < fill_r);
            end else begin
                pad_mask_s[i] = 1'b1;
            end
        end

        data_out_s = acc_r[OUT_W-1:0] & pad_mask_s;
    end

    // Next accumulator contents, fill and flush bookkeeping.
    always_comb begin
        push_s      = gb.in_valid && in_ready_s;
        pop_s       = out_valid_s && gb.out_ready;
        acc_next_s  = acc_r;
        fill_next_s = fill_r;
        pend_next_s = flush_pend_r || gb.flush;
        done_next_s = 1'b0;

        // Pop first, so a simultaneous push lands at fill - consumed.
        if (pop_s) begin
            acc_next_s  = acc_r >> consumed_s;
            fill_next_s = fill_r - consumed_s;
        end else begin
            acc_next_s  = acc_r;
            fill_next_s = fill_r;
        end

        if (push_s) begin
            acc_next_s  = acc_next_s | (BUF_W'(gb.data_in) << fill_next_s);
            fill_next_s = fill_next_s + IN_W_X;
        end else begin
            acc_next_s  = acc_next_s;
            fill_next_s = fill_next_s;
        end

        // A flush (new or pending) completes as soon as the buffer is empty.
        if (pend_next_s && (fill_next_s == FILL_ZERO)) begin
            pend_next_s = 1'b0;
            done_next_s = 1'b1;
        end else begin
            done_next_s = 1'b0;
        end
    end

    // State registers; reset discards buffered data and cancels any flush.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            acc_r        <= {BUF_W{1'b0}};
            fill_r       <= FILL_ZERO;
            flush_pend_r <= 1'b0;
            flush_done_r <= 1'b0;
        end else begin
            acc_r        <= acc_next_s;
            fill_r       <= fill_next_s;
            flush_pend_r <= pend_next_s;
            flush_done_r <= done_next_s;
        end
    end

    assign gb.in_ready   = in_ready_s;
    assign gb.out_valid  = out_valid_s;
    assign gb.data_out   = data_out_s;
    assign gb.out_last   = padded_s;
    assign gb.flush_done = flush_done_r;
    assign gb.level      = fill_r[LVL_W-1:0];

endmodule

// File: tb/tb_gearbox_param.sv
// tb_gearbox_param: directed self-checking bench for gearbox_param.
// dut_a is the default 16->20 / 80-bit configuration, dut_b is 20->16 / 40-bit.
module tb_gearbox_param;

    logic clk = 1'b0;
    logic res;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    gearbox_param_if #(.IN_W(16), .OUT_W(20), .BUF_W(80)) ia ();
    gearbox_param_if #(.IN_W(20), .OUT_W(16), .BUF_W(40)) ib ();

    gearbox_param #(.IN_W(16), .OUT_W(20), .BUF_W(80)) dut_a (.clk(clk), .res(res), .gb(ia));
    gearbox_param #(.IN_W(20), .OUT_W(16), .BUF_W(40)) dut_b (.clk(clk), .res(res), .gb(ib));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [19:0] d,
                         input logic l, input int lvl);
        chk({tag, ".valid"}, 32'(ia.out_valid), 32'(v));
        if (v) chk({tag, ".data"}, 32'(ia.data_out), 32'(d));
        chk({tag, ".last"}, 32'(ia.out_last), 32'(l));
        chk({tag, ".level"}, 32'(ia.level), 32'(lvl));
    endtask

    task automatic chk_b(input string tag, input logic v, input logic [15:0] d,
                         input logic l, input int lvl);
        chk({tag, ".valid"}, 32'(ib.out_valid), 32'(v));
        if (v) chk({tag, ".data"}, 32'(ib.data_out), 32'(d));
        chk({tag, ".last"}, 32'(ib.out_last), 32'(l));
        chk({tag, ".level"}, 32'(ib.level), 32'(lvl));
    endtask

    task automatic drive_a(input logic v, input logic [15:0] d, input logic f, input logic r);
        ia.in_valid  = v;
        ia.data_in   = d;
        ia.flush     = f;
        ia.out_ready = r;
    endtask

    task automatic drive_b(input logic v, input logic [19:0] d, input logic f, input logic r);
        ib.in_valid  = v;
        ib.data_in   = d;
        ib.flush     = f;
        ib.out_ready = r;
    endtask

    // 16->20 stream 1..5 with the consumer always ready.
    task automatic run_s1(input string p);
        drive_a(1'b1, 16'h0001, 1'b0, 1'b1);
        chk({p, ".rdy"}, 32'(ia.in_ready), 32'd1);
        chk_a({p, ".c0"}, 1'b0, 20'h0, 1'b0, 0);
        tick();
        chk_a({p, ".c1"}, 1'b0, 20'h0, 1'b0, 16);
        drive_a(1'b1, 16'h0002, 1'b0, 1'b1);
        tick();
        chk_a({p, ".c2"}, 1'b1, 20'h20001, 1'b0, 32);
        drive_a(1'b1, 16'h0003, 1'b0, 1'b1);
        tick();
        chk_a({p, ".c3"}, 1'b1, 20'h03000, 1'b0, 28);
        drive_a(1'b1, 16'h0004, 1'b0, 1'b1);
        tick();
        chk_a({p, ".c4"}, 1'b1, 20'h00400, 1'b0, 24);
        drive_a(1'b1, 16'h0005, 1'b0, 1'b1);
        tick();
        chk_a({p, ".c5"}, 1'b1, 20'h00050, 1'b0, 20);
        drive_a(1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        chk_a({p, ".c6"}, 1'b0, 20'h0, 1'b0, 0);
        chk({p, ".done"}, 32'(ia.flush_done), 32'd0);
        drive_a(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res = 1'b1;
        drive_a(1'b0, 16'h0000, 1'b0, 1'b0);
        drive_b(1'b0, 20'h00000, 1'b0, 1'b0);
        #3;
        // Reset state
        chk("rst.a_rdy", 32'(ia.in_ready), 32'd0);
        chk("rst.a_done", 32'(ia.flush_done), 32'd0);
        chk("rst.a_data", 32'(ia.data_out), 32'd0);
        chk_a("rst.a", 1'b0, 20'h0, 1'b0, 0);
        chk("rst.b_rdy", 32'(ib.in_ready), 32'd0);
        chk_b("rst.b", 1'b0, 16'h0, 1'b0, 0);
        tick();
        tick();
        res = 1'b0;
        #1;
        chk("rel.a_rdy", 32'(ia.in_ready), 32'd1);
        chk("rel.b_rdy", 32'(ib.in_ready), 32'd1);

        // Scenario 1: basic 16->20 stream
        run_s1("s1");

        // Scenario 2: 20->16 with padded flush tail
        drive_b(1'b1, 20'hABCDE, 1'b0, 1'b0);
        tick();
        chk_b("s2.w0", 1'b1, 16'hBCDE, 1'b0, 20);
        drive_b(1'b1, 20'h12345, 1'b0, 1'b1);
        tick();
        chk_b("s2.w1", 1'b1, 16'h345A, 1'b0, 24);
        drive_b(1'b0, 20'h00000, 1'b0, 1'b1);
        tick();
        chk_b("s2.rem", 1'b0, 16'h0, 1'b0, 8);
        drive_b(1'b0, 20'h00000, 1'b1, 1'b1);
        tick();
        chk_b("s2.pad", 1'b1, 16'h0012, 1'b1, 8);
        chk("s2.pad_rdy", 32'(ib.in_ready), 32'd0);
        chk("s2.pad_done", 32'(ib.flush_done), 32'd0);
        drive_b(1'b0, 20'h00000, 1'b0, 1'b1);
        tick();
        chk_b("s2.empty", 1'b0, 16'h0, 1'b0, 0);
        chk("s2.done", 32'(ib.flush_done), 32'd1);
        drive_b(1'b0, 20'h00000, 1'b0, 1'b0);
        tick();
        chk("s2.done_off", 32'(ib.flush_done), 32'd0);
        chk("s2.rdy", 32'(ib.in_ready), 32'd1);

        // Scenario 3: fill to capacity with consumer stalled
        for (int k = 1; k <= 5; k++) begin
            drive_a(1'b1, 16'(k), 1'b0, 1'b0);
            chk("s3.rdy_fill", 32'(ia.in_ready), 32'd1);
            tick();
        end
        chk_a("s3.full", 1'b1, 20'h20001, 1'b0, 80);
        chk("s3.full_rdy", 32'(ia.in_ready), 32'd0);
        drive_a(1'b1, 16'h0006, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_a("s3.hold", 1'b1, 20'h20001, 1'b0, 80);
            chk("s3.hold_rdy", 32'(ia.in_ready), 32'd0);
        end
        // Drain two words, then flush at level 40 (exact multiple of OUT_W)
        drive_a(1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        chk_a("s3.d1", 1'b1, 20'h03000, 1'b0, 60);
        tick();
        chk_a("s3.d2", 1'b1, 20'h00400, 1'b0, 40);
        drive_a(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        chk_a("s5.f40", 1'b1, 20'h00400, 1'b0, 40);
        chk("s5.f40_rdy", 32'(ia.in_ready), 32'd0);
        chk("s5.f40_done", 32'(ia.flush_done), 32'd0);
        drive_a(1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        chk_a("s5.f20", 1'b1, 20'h00050, 1'b0, 20);
        chk("s5.f20_done", 32'(ia.flush_done), 32'd0);
        tick();
        chk_a("s5.f0", 1'b0, 20'h0, 1'b0, 0);
        chk("s5.f0_done", 32'(ia.flush_done), 32'd1);
        drive_a(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("s5.f0_done_off", 32'(ia.flush_done), 32'd0);
        chk("s5.f0_rdy", 32'(ia.in_ready), 32'd1);

        // Scenario 4: push and flush in the same cycle
        drive_a(1'b1, 16'hABCD, 1'b1, 1'b0);
        tick();
        chk_a("s4.pad", 1'b1, 20'h0ABCD, 1'b1, 16);
        chk("s4.rdy", 32'(ia.in_ready), 32'd0);
        drive_a(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        chk_a("s4.hold", 1'b1, 20'h0ABCD, 1'b1, 16);
        drive_a(1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        chk_a("s4.empty", 1'b0, 20'h0, 1'b0, 0);
        chk("s4.done", 32'(ia.flush_done), 32'd1);
        drive_a(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("s4.done_off", 32'(ia.flush_done), 32'd0);
        chk("s4.rdy_back", 32'(ia.in_ready), 32'd1);

        // Scenario 5: flush with an empty buffer
        drive_a(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        chk_a("s5.e", 1'b0, 20'h0, 1'b0, 0);
        chk("s5.e_done", 32'(ia.flush_done), 32'd1);
        chk("s5.e_rdy", 32'(ia.in_ready), 32'd1);
        drive_a(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("s5.e_done_off", 32'(ia.flush_done), 32'd0);
        chk("s5.e_valid", 32'(ia.out_valid), 32'd0);

        // Scenario 6: reset mid-stream with a pending flush
        for (int k = 1; k <= 3; k++) begin
            drive_a(1'b1, 16'(k), 1'b0, 1'b0);
            tick();
        end
        chk_a("s6.l48", 1'b1, 20'h20001, 1'b0, 48);
        drive_a(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        drive_a(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("s6.pend_rdy", 32'(ia.in_ready), 32'd0);
        res = 1'b1;
        #1;
        chk_a("s6.rst", 1'b0, 20'h0, 1'b0, 0);
        chk("s6.rst_rdy", 32'(ia.in_ready), 32'd0);
        chk("s6.rst_done", 32'(ia.flush_done), 32'd0);
        tick();
        chk("s6.rst_done2", 32'(ia.flush_done), 32'd0);
        res = 1'b0;
        #1;
        chk("s6.rel_rdy", 32'(ia.in_ready), 32'd1);
        tick();
        chk("s6.rel_done", 32'(ia.flush_done), 32'd0);
        chk_a("s6.rel", 1'b0, 20'h0, 1'b0, 0);
        run_s1("s6.again");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
